// File: rtl/ysyx_220053_pkg.sv
// Shared types and constants for the M-stage load/store unit.
// MemOp encodings, FSM state enum and byte-strobe size masks.
package ysyx_220053_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_D  = 3'b011,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101,
        MEM_WU = 3'b110
    } mem_op_e;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    localparam logic ERR_MISALIGN = 1'b0;
    localparam logic ERR_TIMEOUT  = 1'b1;

    function automatic logic [7:0] size_mask(input mem_op_e op);
        case (op)
            MEM_B, MEM_BU: size_mask = MASK_B;
            MEM_H, MEM_HU: size_mask = MASK_H;
            MEM_W, MEM_WU: size_mask = MASK_W;
            default:       size_mask = MASK_D;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_220053_lsu_align.sv
// Byte-lane steering: store strobes/data and misalignment from live inputs,
// load extraction and extension from the latched op/offset.
module ysyx_220053_lsu_align
    import ysyx_220053_pkg::*;
(
    input  mem_op_e     st_op,
    input  logic [2:0]  st_addr_lo,
    input  logic [63:0] st_wdata,
    output logic [7:0]  st_wmask,
    output logic [63:0] st_wdata_sh,
    output logic        st_misaligned,
    input  mem_op_e     ld_op,
    input  logic [2:0]  ld_addr_lo,
    input  logic [63:0] ld_rdata,
    output logic [63:0] ld_result
);

    logic [63:0] ld_raw;

    always_comb begin
        st_wmask    = size_mask(st_op) << st_addr_lo;
        st_wdata_sh = st_wdata << {st_addr_lo, 3'b000};
        case (st_op)
            MEM_H, MEM_HU: st_misaligned = st_addr_lo[0];
            MEM_W, MEM_WU: st_misaligned = |st_addr_lo[1:0];
            MEM_D:         st_misaligned = |st_addr_lo;
            default:       st_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        ld_raw = ld_rdata >> {ld_addr_lo, 3'b000};
        case (ld_op)
            MEM_B:   ld_result = {{56{ld_raw[7]}},  ld_raw[7:0]};
            MEM_H:   ld_result = {{48{ld_raw[15]}}, ld_raw[15:0]};
            MEM_W:   ld_result = {{32{ld_raw[31]}}, ld_raw[31:0]};
            MEM_BU:  ld_result = {56'd0, ld_raw[7:0]};
            MEM_HU:  ld_result = {48'd0, ld_raw[15:0]};
            MEM_WU:  ld_result = {32'd0, ld_raw[31:0]};
            default: ld_result = ld_raw;
        endcase
    end

endmodule

// File: rtl/ysyx_220053_lsu.sv
// M-stage load/store unit: stalls the pipeline while one bus access runs,
// then pulses done with the extended load result or an abort cause.
//
// state | meaning
// IDLE  | no access; a memory instruction starts here (block raised same cycle)
// REQ   | mem_req_valid held with latched fields until mem_req_ready
// WAIT  | load accepted, waiting for mem_resp_valid
// DONE  | one-cycle done pulse, block released so stage registers advance
module ysyx_220053_lsu
    import ysyx_220053_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        MemToReg,
    input  logic        MemWen,
    input  logic [2:0]  MemOp,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        block,
    output logic        done,
    output logic [63:0] rdata,
    output logic        err,
    output logic        err_cause,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    mem_op_e     op_q, op_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        err_cause_q, err_cause_d;
    logic [31:0] cnt_q, cnt_d;
    logic [63:0] rdata_raw_q, rdata_raw_d;

    logic        start;
    logic        timeout_hit;
    logic [7:0]  st_wmask;
    logic [63:0] st_wdata_sh;
    logic        st_misaligned;
    logic [63:0] ld_result;

    assign start       = req_valid & (MemToReg | MemWen);
    assign timeout_hit = (cnt_q >= TO_LAST);

    ysyx_220053_lsu_align u_align (
        .st_op         (mem_op_e'(MemOp)),
        .st_addr_lo    (addr[2:0]),
        .st_wdata      (wdata),
        .st_wmask      (st_wmask),
        .st_wdata_sh   (st_wdata_sh),
        .st_misaligned (st_misaligned),
        .ld_op         (op_q),
        .ld_addr_lo    (addr_q[2:0]),
        .ld_rdata      (rdata_raw_q),
        .ld_result     (ld_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (start) state_d = st_misaligned ? LSU_DONE : LSU_REQ;
            LSU_REQ: begin
                if (mem_req_ready)    state_d = we_q ? LSU_DONE : LSU_WAIT;
                else if (timeout_hit) state_d = LSU_DONE;
            end
            LSU_WAIT: if (mem_resp_valid || timeout_hit) state_d = LSU_DONE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        block         = rst & (((state_q == LSU_IDLE) & start) |
                               (state_q == LSU_REQ) | (state_q == LSU_WAIT));
        done          = (state_q == LSU_DONE);
        err           = done & err_q;
        err_cause     = done & err_cause_q;
        rdata         = (done & ~err_q & ~we_q) ? ld_result : 64'd0;
        mem_req_valid = (state_q == LSU_REQ);
        mem_we        = we_q;
        mem_addr      = {addr_q[63:3], 3'b000};
        mem_wdata     = wdata_q;
        mem_wmask     = wmask_q;
    end

    // Datapath latches; a response arriving on the last counted cycle still wins over timeout.
    always_comb begin
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        we_d        = we_q;
        err_d       = err_q;
        err_cause_d = err_cause_q;
        cnt_d       = cnt_q;
        rdata_raw_d = rdata_raw_q;
        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    op_d        = mem_op_e'(MemOp);
                    addr_d      = addr;
                    we_d        = MemWen;
                    wmask_d     = MemWen ? st_wmask : 8'd0;
                    wdata_d     = MemWen ? st_wdata_sh : 64'd0;
                    err_d       = st_misaligned;
                    err_cause_d = ERR_MISALIGN;
                    cnt_d       = 32'd0;
                    rdata_raw_d = 64'd0;
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (!mem_req_ready && timeout_hit) begin
                    err_d       = 1'b1;
                    err_cause_d = ERR_TIMEOUT;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_resp_valid) begin
                    rdata_raw_d = mem_rdata;
                end else if (timeout_hit) begin
                    err_d       = 1'b1;
                    err_cause_d = ERR_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q        <= MEM_B;
            addr_q      <= 64'd0;
            wdata_q     <= 64'd0;
            wmask_q     <= 8'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            err_cause_q <= 1'b0;
            cnt_q       <= 32'd0;
            rdata_raw_q <= 64'd0;
        end else begin
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            we_q        <= we_d;
            err_q       <= err_d;
            err_cause_q <= err_cause_d;
            cnt_q       <= cnt_d;
            rdata_raw_q <= rdata_raw_d;
        end
    end

endmodule

// File: tb/tb_ysyx_220053_lsu.sv
// Scoreboard bench for ysyx_220053_lsu: each access pushes its expected
// completion; a negedge monitor pops and compares whenever done fires.
module tb_ysyx_220053_lsu;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        cause;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        MemToReg = 1'b0;
    logic        MemWen = 1'b0;
    logic [2:0]  MemOp = 3'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_rdata = 64'd0;
    logic        block, done, err, err_cause, mem_req_valid, mem_we;
    logic [63:0] rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    exp_t sb[$];

    ysyx_220053_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .MemToReg(MemToReg),
        .MemWen(MemWen), .MemOp(MemOp), .addr(addr), .wdata(wdata),
        .block(block), .done(done), .rdata(rdata), .err(err), .err_cause(err_cause),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("err", 64'(err), 64'(e.err));
                chk("err_cause", 64'(err_cause), 64'(e.cause));
                chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
                chk("done_req_valid", 64'(mem_req_valid), 64'd0);
            end
        end
    end

    task automatic do_access(input logic wen, input logic m2r, input logic [2:0] op,
                             input logic [63:0] a, input logic [63:0] wd, input logic rdy,
                             input int resp_dly, input logic [63:0] mrd, input exp_t e,
                             input logic exp_bus, input logic [7:0] exp_mask,
                             input logic [63:0] exp_wd);
        int hs;
        bit fin;
        bit seen_req;
        @(posedge clk); #1;
        req_valid = 1'b1; MemWen = wen; MemToReg = m2r; MemOp = op; addr = a; wdata = wd;
        mem_req_ready = rdy; mem_resp_valid = 1'b0; mem_rdata = mrd;
        start_cyc = cyc;
        sb.push_back(e);
        hs = -1; fin = 0; seen_req = 0;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clk);
            chk("block", 64'(block), 64'((cyc - start_cyc) < e.lat));
            if (!done) begin
                chk("idle_rdata", rdata, 64'd0);
                chk("idle_err", 64'(err), 64'd0);
            end
            if (mem_req_valid && !seen_req) begin
                seen_req = 1;
                chk("mem_addr", mem_addr, {a[63:3], 3'b000});
                chk("mem_we", 64'(mem_we), 64'(wen));
                chk("mem_wmask", 64'(mem_wmask), 64'(exp_mask));
                chk("mem_wdata", mem_wdata, exp_wd);
            end
            if (mem_req_valid && mem_req_ready && hs < 0) hs = cyc - start_cyc;
            if (done) fin = 1;
            @(posedge clk); #1;
            mem_resp_valid = (hs >= 0 && resp_dly >= 0 && (cyc - start_cyc) == hs + resp_dly);
        end
        chk("finished", 64'(fin), 64'd1);
        chk("bus_access", 64'(seen_req), 64'(exp_bus));
        req_valid = 1'b0; MemWen = 1'b0; MemToReg = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a live load request on the inputs: everything must stay quiet.
        req_valid = 1'b1; MemToReg = 1'b1; MemOp = 3'b011; addr = 64'h8000_0000;
        #3;
        chk("rst_block", 64'(block), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cause", 64'(err_cause), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        chk("rst_wmask", 64'(mem_wmask), 64'd0);
        @(negedge clk);
        req_valid = 1'b0; MemToReg = 1'b0;
        rst = 1'b1;

        // sb, store latency 2
        do_access(1, 0, 3'b000, 64'h8000_0005, 64'hAB, 1, -1, 64'd0,
                  '{64'd0, 1'b0, 1'b0, 2}, 1, 8'h20, 64'h0000_AB00_0000_0000);
        // lh, response 3 cycles after handshake, lands on the last counted cycle
        do_access(0, 1, 3'b001, 64'h8000_0006, 64'd0, 1, 3, 64'h8001_0000_0000_0000,
                  '{64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0, 5}, 1, 8'h00, 64'd0);
        // lwu
        do_access(0, 1, 3'b110, 64'h8000_0004, 64'd0, 1, 1, 64'hF000_0000_0000_0000,
                  '{64'h0000_0000_F000_0000, 1'b0, 1'b0, 3}, 1, 8'h00, 64'd0);
        // misaligned ld
        do_access(0, 1, 3'b011, 64'h8000_0003, 64'd0, 1, -1, 64'd0,
                  '{64'd0, 1'b1, 1'b0, 1}, 0, 8'h00, 64'd0);
        // timeout in REQ
        do_access(0, 1, 3'b011, 64'h8000_0008, 64'd0, 0, -1, 64'h1234_5678_9ABC_DEF0,
                  '{64'd0, 1'b1, 1'b1, 5}, 1, 8'h00, 64'd0);
        // timeout in WAIT
        do_access(0, 1, 3'b010, 64'h8000_0010, 64'd0, 1, -1, 64'hFFFF_FFFF_FFFF_FFFF,
                  '{64'd0, 1'b1, 1'b1, 5}, 1, 8'h00, 64'd0);
        // sd with both MemWen and MemToReg set behaves as a store
        do_access(1, 1, 3'b011, 64'h8000_0018, 64'h1122_3344_5566_7788, 1, -1, 64'd0,
                  '{64'd0, 1'b0, 1'b0, 2}, 1, 8'hFF, 64'h1122_3344_5566_7788);
        // misaligned sh
        do_access(1, 0, 3'b001, 64'h8000_0001, 64'h55AA, 1, -1, 64'd0,
                  '{64'd0, 1'b1, 1'b0, 1}, 0, 8'h00, 64'd0);
        // sw upper word
        do_access(1, 0, 3'b010, 64'h8000_0004, 64'hDEAD_BEEF, 1, -1, 64'd0,
                  '{64'd0, 1'b0, 1'b0, 2}, 1, 8'hF0, 64'hDEAD_BEEF_0000_0000);
        // lhu
        do_access(0, 1, 3'b101, 64'h8000_0002, 64'd0, 1, 2, 64'h0000_0000_BEEF_0000,
                  '{64'h0000_0000_0000_BEEF, 1'b0, 1'b0, 4}, 1, 8'h00, 64'd0);
        // lw sign extension
        do_access(0, 1, 3'b010, 64'h8000_0000, 64'd0, 1, 1, 64'h0000_0000_8000_0001,
                  '{64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0, 3}, 1, 8'h00, 64'd0);
        // lb top byte, negative
        do_access(0, 1, 3'b000, 64'h8000_0007, 64'd0, 1, 1, 64'h8000_0000_0000_0000,
                  '{64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 3}, 1, 8'h00, 64'd0);

        // Non-memory instruction: no stall, no bus activity.
        @(posedge clk); #1;
        req_valid = 1'b1; MemToReg = 1'b0; MemWen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nonmem_block", 64'(block), 64'd0);
            chk("nonmem_done", 64'(done), 64'd0);
            chk("nonmem_req_valid", 64'(mem_req_valid), 64'd0);
        end
        req_valid = 1'b0;

        // Reset while in WAIT, then a stale response after reset.
        @(posedge clk); #1;
        req_valid = 1'b1; MemToReg = 1'b1; MemOp = 3'b011; addr = 64'h8000_0020;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_block", 64'(block), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_block", 64'(block), 64'd0);
        chk("midrst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        req_valid = 1'b0; MemToReg = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("stale_resp_done", 64'(done), 64'd0);
        chk("stale_resp_block", 64'(block), 64'd0);

        // lb after reset completes normally
        do_access(0, 1, 3'b000, 64'h8000_0002, 64'd0, 1, 1, 64'h0000_0000_005A_0000,
                  '{64'h0000_0000_0000_005A, 1'b0, 1'b0, 3}, 1, 8'h00, 64'd0);

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_220053_lsu.md
YSYX_220053_LSU -- requirements
Module: ysyx_220053_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, which is the maximum number of cycles in REQ+WAIT before the access aborts.
REQ-002 SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  M-stage holds a valid instruction.
- MemToReg  in  1  instruction is a load.
- MemWen  in  1  instruction is a store.
- MemOp  in  3  000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- addr  in  64  byte address (M-stage ALURes).
- wdata  in  64  store data, right-justified.
- block  out  1  stall request to all upstream stage registers.
- done  out  1  one-cycle completion pulse.
- rdata  out  64  extended load result, valid while done=1.
- err  out  1  access aborted, valid while done=1.
- err_cause  out  1  0 = misaligned, 1 = timeout.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts the request.
- mem_we  out  1  request is a write.
- mem_addr  out  64  {addr[63:3],3'b0}.
- mem_wdata  out  64  shifted store data.
- mem_wmask  out  8  byte strobes.
- mem_resp_valid  in  1  read data valid.
- mem_rdata  in  64  aligned doubleword.

Function
REQ-003 SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
REQ-004 SHALL define start = req_valid & (MemToReg|MemWen) in IDLE; when MemWen and MemToReg are both set, the access SHALL be treated as a store.
REQ-005 SHALL latch op, addr, wdata, wmask and we in IDLE when start=1.
- Aligned access: go to REQ.
- Misaligned access (h with addr[0]; w with addr[1:0]≠0; d with addr[2:0]≠0): go directly to DONE with err=1 and err_cause=0, and issue no bus access.
REQ-006 SHALL assert block combinationally = (IDLE & start) | REQ | WAIT, and SHALL drive block=0 in DONE so that the stage registers advance on that edge.
REQ-007 SHALL, in REQ, drive mem_req_valid=1 with stable latched fields until mem_req_ready=1.
- Handshake with a store: go to DONE.
- Handshake with a load: go to WAIT.
REQ-008 SHALL, in WAIT, capture mem_rdata and go to DONE on mem_resp_valid=1.
REQ-009 SHALL assert done=1 in DONE for exactly one cycle, always return to IDLE next, and ignore req_valid in DONE.
REQ-010 SHALL clear a cycle counter on entry to REQ and increment it in REQ and WAIT.
- When the count reaches TIMEOUT-1 without completion: go to DONE with err=1, err_cause=1, rdata=0, and mem_req_valid deasserted.
REQ-011 SHALL form the store outputs as follows:
- mem_wmask = size mask (b 0x01, h 0x03, w 0x0F, d 0xFF) << addr[2:0].
- mem_wdata = wdata << 8*addr[2:0].
REQ-012 SHALL form the load result as follows:
- Shift: raw = mem_rdata >> 8*addr[2:0], truncated to size.
- Extension: b, h and w sign-extend; bu, hu and wu zero-extend; d passes through.
REQ-013 SHALL drive mem_we=0 and mem_wmask=0 for loads.
REQ-014 SHALL drive rdata=0 and err=0 whenever done=0.
REQ-015 SHALL produce a store latency of 2 cycles start-to-done when mem_req_ready is held at 1.
REQ-016 SHALL produce a load latency of 2+N cycles start-to-done, where N is the response delay in cycles after the handshake.
REQ-017 SHALL hold the outputs of a non-memory instruction at block=0 and done=0 with no bus activity.

Reset
REQ-018 SHALL, on rst=0, force IDLE asynchronously and clear the counter and all latches.
REQ-019 SHALL drive block, done, err, err_cause, mem_req_valid and mem_we to 0, and rdata, mem_addr, mem_wdata and mem_wmask to 0, while rst=0.
REQ-020 SHALL drop mem_req_valid immediately when reset occurs mid-access and discard any late mem_resp_valid after reset.

Structure
REQ-021 SHALL take the MemOp encodings, the FSM state enum and the size-mask constants from the shared package ysyx_220053_pkg.
REQ-022 SHALL place store alignment and load extraction in one combinational sub-module, ysyx_220053_lsu_align.

Verification
REQ-023 SHALL verify an sb: addr=0x80000005, wdata=0xAB, ready=1 -> mem_addr=0x80000000, wmask=0x20, wdata=0x0000AB0000000000, done at cycle 2.
REQ-024 SHALL verify an lh: addr=0x80000006, mem_rdata=0x8001_0000_0000_0000, resp delay 3 -> rdata=0xFFFFFFFFFFFF8001, done at cycle 5, block high on cycles 0-4.
REQ-025 SHALL verify an lwu: addr=0x80000004, mem_rdata=0xF0000000_00000000 -> rdata=0x00000000F0000000.
REQ-026 SHALL verify a misaligned ld: addr=0x80000003 -> no mem_req_valid, done next cycle with err=1 and err_cause=0.
REQ-027 SHALL verify a timeout: TIMEOUT=4 with ready held at 0 -> done with err=1, err_cause=1, rdata=0.
REQ-028 SHALL verify reset in WAIT: rst=0 mid-access -> mem_req_valid=0 and block=0 immediately; a following lb completes normally.
